// File: rtl/riot_timer_bank.sv
// riot_timer_bank: NUM_CH 6532-style down-counters with 1/8/64/1024 prescalers, flags and a shared IRQ_n.
// Define RIOT_TIMER_RELOAD_EN to implement the CTRL reload bit (restart from LOAD on underflow).
module riot_timer_bank #(
  parameter int NUM_CH  = 4,
  parameter int TIMER_W = 8
) (
  input  logic       CLK,
  input  logic       RES_n,
  input  logic [5:0] A,
  input  logic [7:0] Din,
  output logic [7:0] Dout,
  input  logic       CS,
  input  logic       CS_n,
  input  logic       R_W_n,
  output logic       IRQ_n
);

`ifdef RIOT_TIMER_RELOAD_EN
  localparam bit RELOAD_EN = 1'b1;
`else
  localparam bit RELOAD_EN = 1'b0;
`endif

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_LOAD_LO  = 2'd1;
  localparam logic [1:0] REG_COUNT_LO = 2'd2;
  localparam logic [1:0] REG_HI       = 2'd3;

  logic       access;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] ch_idx;
  logic [1:0] reg_sel;

  assign access  = CS & ~CS_n;
  assign wr_en   = access & ~R_W_n;
  assign rd_en   = access & R_W_n;
  assign ch_idx  = A[5:2];
  assign reg_sel = A[1:0];

  logic [NUM_CH-1:0][7:0] ctrl_rd;
  logic [NUM_CH-1:0][7:0] cnt_lo_rd;
  logic [NUM_CH-1:0][7:0] hi_rd;
  logic [NUM_CH-1:0]      irq_vec;

  function automatic logic [9:0] div_m1(input logic [1:0] s);
    case (s)
      2'd0:    return 10'd0;
      2'd1:    return 10'd7;
      2'd2:    return 10'd63;
      default: return 10'd1023;
    endcase
  endfunction

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [TIMER_W-1:0] count_q, count_d;
    logic [TIMER_W-1:0] load_q, load_d;
    logic [9:0]         presc_q, presc_d;
    logic [1:0]         sel_q, sel_d;
    logic               irq_en_q, irq_en_d;
    logic               reload_q, reload_d;
    logic               flag_q, flag_d;
    logic               free_q, free_d;
    logic [7:0]         hi_latch_q, hi_latch_d;
    logic               hit;
    logic               underflow;

    assign hit = (ch_idx == 4'(gi));

    always_comb begin
      count_d    = count_q;
      load_d     = load_q;
      presc_d    = presc_q;
      sel_d      = sel_q;
      irq_en_d   = irq_en_q;
      reload_d   = reload_q;
      flag_d     = flag_q;
      free_d     = free_q;
      hi_latch_d = hi_latch_q;
      underflow  = 1'b0;

      if (presc_q != 10'd0) begin
        presc_d = presc_q - 10'd1;
      end else if (count_q == '0) begin
        underflow = 1'b1;
        flag_d    = 1'b1;
        if (RELOAD_EN && reload_q) begin
          count_d = load_q;
          presc_d = div_m1(sel_q);
        end else begin
          // Wrap and stay in 1x mode until software reads COUNT_LO or reloads.
          count_d = '1;
          presc_d = 10'd0;
          free_d  = 1'b1;
        end
      end else begin
        count_d = count_q - TIMER_W'(1);
        presc_d = free_q ? 10'd0 : div_m1(sel_q);
      end

      // Bus writes are applied last so a LOAD on the underflow edge wins.
      if (wr_en && hit) begin
        case (reg_sel)
          REG_CTRL: begin
            sel_d    = Din[1:0];
            irq_en_d = Din[2];
            reload_d = RELOAD_EN & Din[3];
          end
          REG_LOAD_LO: begin
            load_d[7:0] = Din;
            count_d     = load_d;
            presc_d     = div_m1(sel_q);
            free_d      = 1'b0;
            flag_d      = 1'b0;
          end
          REG_HI: begin
            if (TIMER_W > 8) load_d = TIMER_W'({Din, load_q[7:0]});
          end
          default: ;
        endcase
      end

      if (rd_en && hit && reg_sel == REG_COUNT_LO) begin
        hi_latch_d = 8'(count_q >> 8);
        if (!underflow) begin
          flag_d = 1'b0;
          free_d = 1'b0;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (!RES_n) begin
        count_q    <= '0;
        load_q     <= '0;
        presc_q    <= '0;
        sel_q      <= '0;
        irq_en_q   <= 1'b0;
        reload_q   <= 1'b0;
        flag_q     <= 1'b0;
        free_q     <= 1'b0;
        hi_latch_q <= '0;
      end else begin
        count_q    <= count_d;
        load_q     <= load_d;
        presc_q    <= presc_d;
        sel_q      <= sel_d;
        irq_en_q   <= irq_en_d;
        reload_q   <= reload_d;
        flag_q     <= flag_d;
        free_q     <= free_d;
        hi_latch_q <= hi_latch_d;
      end
    end

    assign ctrl_rd[gi]   = {flag_q, 3'b000, reload_q, irq_en_q, sel_q};
    assign cnt_lo_rd[gi] = count_q[7:0];
    assign hi_rd[gi]     = hi_latch_q;
    assign irq_vec[gi]   = flag_q & irq_en_q;
  end

  logic [7:0] rd_data;
  logic [7:0] dout_q;

  // Unmatched channel indices and the write-only LOAD_LO slot read as zero.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 4'(i)) begin
        case (reg_sel)
          REG_CTRL:     rd_data = ctrl_rd[i];
          REG_COUNT_LO: rd_data = cnt_lo_rd[i];
          REG_HI:       rd_data = hi_rd[i];
          default:      rd_data = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RES_n) begin
      dout_q <= 8'h00;
    end else if (rd_en) begin
      dout_q <= rd_data;
    end
  end

  assign Dout  = dout_q;
  assign IRQ_n = ~|irq_vec;

endmodule

// File: tb/tb_riot_timer_bank.sv
// tb_riot_timer_bank: directed + random bus traffic on a 4-channel, 16-bit bank,
// checked every cycle against a behavioural model of the timer rules.
module tb_riot_timer_bank;
  localparam int NCH  = 4;
  localparam int TW   = 16;
  localparam int CMAX = (1 << TW) - 1;
`ifdef RIOT_TIMER_RELOAD_EN
  localparam bit RL = 1'b1;
`else
  localparam bit RL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res_n;
  logic [5:0] a;
  logic [7:0] din;
  logic [7:0] dout;
  logic       cs;
  logic       cs_n;
  logic       r_w_n;
  logic       irq_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riot_timer_bank #(.NUM_CH(NCH), .TIMER_W(TW)) dut (
    .CLK   (clk),
    .RES_n (res_n),
    .A     (a),
    .Din   (din),
    .Dout  (dout),
    .CS    (cs),
    .CS_n  (cs_n),
    .R_W_n (r_w_n),
    .IRQ_n (irq_n)
  );

  // Reference model state
  int m_count [NCH];
  int m_load  [NCH];
  int m_presc [NCH];
  int m_sel   [NCH];
  int m_hi    [NCH];
  bit m_irq_en[NCH];
  bit m_reload[NCH];
  bit m_flag  [NCH];
  bit m_free  [NCH];
  int m_dout;

  function automatic int div_of(int s);
    case (s)
      0:       return 1;
      1:       return 8;
      2:       return 64;
      default: return 1024;
    endcase
  endfunction

  function automatic logic model_irq_n();
    for (int c = 0; c < NCH; c++)
      if (m_flag[c] && m_irq_en[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(bit rst_n, bit acc, bit rw, int addr, int d);
    int ch, r, dv;
    bit uf;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_count[c] = 0; m_load[c] = 0; m_presc[c] = 0; m_sel[c] = 0; m_hi[c] = 0;
        m_irq_en[c] = 0; m_reload[c] = 0; m_flag[c] = 0; m_free[c] = 0;
      end
      m_dout = 0;
      return;
    end
    ch = addr / 4;
    r  = addr % 4;
    if (acc && rw) begin
      if (ch >= NCH) m_dout = 0;
      else begin
        case (r)
          0: m_dout = int'(m_flag[ch]) * 128 + int'(m_reload[ch]) * 8 + int'(m_irq_en[ch]) * 4 + m_sel[ch];
          2: begin m_dout = m_count[ch] % 256; m_hi[ch] = m_count[ch] / 256; end
          3: m_dout = m_hi[ch];
          default: m_dout = 0;
        endcase
      end
    end
    for (int c = 0; c < NCH; c++) begin
      dv = div_of(m_sel[c]);
      uf = 0;
      if (m_presc[c] > 0) m_presc[c]--;
      else if (m_count[c] == 0) begin
        uf = 1;
        m_flag[c] = 1;
        if (RL && m_reload[c]) begin m_count[c] = m_load[c]; m_presc[c] = dv - 1; end
        else begin m_count[c] = CMAX; m_presc[c] = 0; m_free[c] = 1; end
      end else begin
        m_count[c]--;
        m_presc[c] = m_free[c] ? 0 : dv - 1;
      end
      if (acc && ch == c) begin
        if (!rw) begin
          case (r)
            0: begin m_sel[c] = d % 4; m_irq_en[c] = d[2]; m_reload[c] = RL & d[3]; end
            1: begin
              m_load[c] = (m_load[c] / 256) * 256 + d;
              m_count[c] = m_load[c]; m_presc[c] = dv - 1; m_free[c] = 0; m_flag[c] = 0;
            end
            3: m_load[c] = (d * 256 + m_load[c] % 256) % (CMAX + 1);
            default: ;
          endcase
        end else if (r == 2 && !uf) begin
          m_flag[c] = 0;
          m_free[c] = 0;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(bit rst_v, bit cs_v, bit csn_v, bit rw_v, logic [5:0] a_v, logic [7:0] d_v);
    res_n = rst_v; cs = cs_v; cs_n = csn_v; r_w_n = rw_v; a = a_v; din = d_v;
    @(posedge clk);
    model_step(rst_v, cs_v && !csn_v, rw_v, int'(a_v), int'(d_v));
    #1;
    chk("dout", {8'h00, dout}, 16'(m_dout));
    chk("irq_n", {15'h0, irq_n}, {15'h0, model_irq_n()});
  endtask

  task automatic wr(int ch, int r, int d);
    step(1'b1, 1'b1, 1'b0, 1'b0, 6'(ch * 4 + r), 8'(d));
  endtask

  task automatic rd(int ch, int r);
    step(1'b1, 1'b1, 1'b0, 1'b1, 6'(ch * 4 + r), 8'h00);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b1, 1'b1, 6'h00, 8'h00);
  endtask

  initial begin
    res_n = 1'b0; cs = 1'b0; cs_n = 1'b1; r_w_n = 1'b1; a = '0; din = '0;
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 8'h00);
    chk("reset_dout", {8'h00, dout}, 16'h0000);
    chk("reset_irq_n", {15'h0, irq_n}, 16'h0001);

    // CH0 /1: 3,2,1,0 with the 0 read landing on the underflow edge
    wr(0, 0, 8'h00);
    wr(0, 1, 8'h03);
    rd(0, 2); chk("ch0_cnt3", {8'h00, dout}, 16'h0003);
    rd(0, 2); chk("ch0_cnt2", {8'h00, dout}, 16'h0002);
    rd(0, 2); chk("ch0_cnt1", {8'h00, dout}, 16'h0001);
    rd(0, 2); chk("ch0_cnt0", {8'h00, dout}, 16'h0000);
    rd(0, 0); chk("ch0_flag_set_wins", {8'h00, dout}, 16'h0080);
    wr(0, 1, 8'h03);
    repeat (4) idle();
    rd(0, 2); chk("ch0_wrap_ff", {8'h00, dout}, 16'h00FF);
    rd(0, 2); chk("ch0_wrap_fe", {8'h00, dout}, 16'h00FE);
    rd(0, 0); chk("ch0_flag_cleared", {8'h00, dout}, 16'h0000);

    // CH1 /8 with IRQ: falls 24 edges after LOAD
    wr(1, 0, 8'h05);
    wr(1, 1, 8'h02);
    for (int k = 1; k <= 24; k++) begin
      idle();
      chk($sformatf("ch1_irq_k%0d", k), {15'h0, irq_n}, (k >= 24) ? 16'h0000 : 16'h0001);
    end
    rd(1, 2); chk("ch1_read_ff", {8'h00, dout}, 16'h00FF);
    chk("ch1_irq_released", {15'h0, irq_n}, 16'h0001);
    repeat (8) idle();
    rd(1, 2); chk("ch1_div8_fd", {8'h00, dout}, 16'h00FD);
    rd(1, 2); chk("ch1_div8_fc", {8'h00, dout}, 16'h00FC);

    // CH2 reload
    wr(2, 0, 8'h08);
`ifdef RIOT_TIMER_RELOAD_EN
    wr(2, 1, 8'h01);
    rd(2, 2); chk("ch2_rl_1a", {8'h00, dout}, 16'h0001);
    rd(2, 2); chk("ch2_rl_0", {8'h00, dout}, 16'h0000);
    rd(2, 2); chk("ch2_rl_1b", {8'h00, dout}, 16'h0001);
    rd(2, 0); chk("ch2_rl_ctrl", {8'h00, dout}, 16'h0008);
    rd(2, 0); chk("ch2_rl_flag", {8'h00, dout}, 16'h0088);
`else
    rd(2, 0); chk("ch2_no_reload_bit", {8'h00, dout}, 16'h0080);
`endif

    // CH3 16-bit lanes
    wr(3, 3, 8'h01);
    wr(3, 1, 8'h00);
    rd(3, 2); chk("ch3_lo_00", {8'h00, dout}, 16'h0000);
    rd(3, 3); chk("ch3_hi_01", {8'h00, dout}, 16'h0001);
    wr(3, 1, 8'h00);
    idle();
    rd(3, 2); chk("ch3_lo_ff", {8'h00, dout}, 16'h00FF);
    rd(3, 3); chk("ch3_hi_00", {8'h00, dout}, 16'h0000);

    // LOAD write on the underflow edge wins
    wr(0, 1, 8'h02);
    idle(); idle();
    wr(0, 1, 8'h05);
    rd(0, 0); chk("ch0_load_wins_flag", {8'h00, dout}, 16'h0000);
    rd(0, 2); chk("ch0_load_wins_cnt", {8'h00, dout}, 16'h0004);

    // Out-of-range channel
    wr(15, 0, 8'hFF); wr(15, 3, 8'h12); wr(15, 1, 8'h34);
    rd(0, 2);
    rd(15, 0); chk("ch15_ctrl", {8'h00, dout}, 16'h0000);
    rd(15, 2); chk("ch15_cnt", {8'h00, dout}, 16'h0000);
    rd(15, 3); chk("ch15_hi", {8'h00, dout}, 16'h0000);

    // Reset mid-count with IRQ asserted
    wr(0, 0, 8'h04);
    rd(1, 2);
    wr(0, 1, 8'h00);
    idle(); chk("pre_reset_irq_low", {15'h0, irq_n}, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 6'h02, 8'h00);
    chk("midreset_irq_n", {15'h0, irq_n}, 16'h0001);
    chk("midreset_dout", {8'h00, dout}, 16'h0000);
    rd(0, 2); chk("post_reset_cnt", {8'h00, dout}, 16'h0000);
    rd(0, 0); chk("post_reset_first_uf", {8'h00, dout}, 16'h0080);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int k, ch, r, d;
      k  = int'($urandom_range(0, 99));
      ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 255));
      if (k < 1) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 6'(ch * 4 + r), 8'(d));
      end else if (k < 25) begin
        if ($urandom_range(0, 1) == 0)
          step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'(ch * 4 + r), 8'(d));
        else
          step(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 6'(ch * 4 + r), 8'(d));
      end else if (k < 60) begin
        if (r == 1) r = 2;
        rd(ch, r);
      end else begin
        if (r == 0 && $urandom_range(0, 3) != 0) d = d % 2 + (d / 4) * 4;
        if (r == 1 && $urandom_range(0, 1) == 0) d = d % 16;
        if (r == 3 && $urandom_range(0, 3) != 0) d = d % 2;
        wr(ch, r, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
